// File: rtl/encap_ekey_lookup_if.sv
// Bundle of request, response, hash-table, value-memory and counter signals
// between the encap ekey lookup engine and its neighbours.
interface encap_ekey_lookup_if #(
  parameter int DEPTH_NBITS       = 10,
  parameter int KEY_NBITS         = 24,
  parameter int VALUE_DEPTH_NBITS = 10,
  parameter int VALUE_NBITS       = 288,
  parameter int TAG_NBITS         = 8,
  parameter int BUCKET_NBITS      = 2*(1+KEY_NBITS+VALUE_DEPTH_NBITS)
);
  logic                         req_valid;
  logic                         req_ready;
  logic [KEY_NBITS-1:0]         req_key;
  logic [DEPTH_NBITS-1:0]       req_hash0;
  logic [DEPTH_NBITS-1:0]       req_hash1;
  logic [TAG_NBITS-1:0]         req_tag;

  logic                         ekey_hash_table0_rd;
  logic [DEPTH_NBITS-1:0]       ekey_hash_table0_raddr;
  logic                         ekey_hash_table0_ack;
  logic [BUCKET_NBITS-1:0]      ekey_hash_table0_rdata;
  logic                         ekey_hash_table1_rd;
  logic [DEPTH_NBITS-1:0]       ekey_hash_table1_raddr;
  logic                         ekey_hash_table1_ack;
  logic [BUCKET_NBITS-1:0]      ekey_hash_table1_rdata;

  logic                         ekey_value_rd;
  logic [VALUE_DEPTH_NBITS-1:0] ekey_value_raddr;
  logic                         ekey_value_ack;
  logic [VALUE_NBITS-1:0]       ekey_value_rdata;

  logic                         resp_valid;
  logic                         resp_ready;
  logic                         resp_hit;
  logic [VALUE_NBITS-1:0]       resp_value;
  logic [TAG_NBITS-1:0]         resp_tag;

  logic [31:0]                  hit_cnt;
  logic [31:0]                  miss_cnt;

  // Environment side: issues lookups, serves memories, consumes responses
  modport master (
    output req_valid, req_key, req_hash0, req_hash1, req_tag,
    input  req_ready,
    input  ekey_hash_table0_rd, ekey_hash_table0_raddr,
    output ekey_hash_table0_ack, ekey_hash_table0_rdata,
    input  ekey_hash_table1_rd, ekey_hash_table1_raddr,
    output ekey_hash_table1_ack, ekey_hash_table1_rdata,
    input  ekey_value_rd, ekey_value_raddr,
    output ekey_value_ack, ekey_value_rdata,
    input  resp_valid, resp_hit, resp_value, resp_tag,
    output resp_ready,
    input  hit_cnt, miss_cnt
  );

  // Lookup engine side
  modport slave (
    input  req_valid, req_key, req_hash0, req_hash1, req_tag,
    output req_ready,
    output ekey_hash_table0_rd, ekey_hash_table0_raddr,
    input  ekey_hash_table0_ack, ekey_hash_table0_rdata,
    output ekey_hash_table1_rd, ekey_hash_table1_raddr,
    input  ekey_hash_table1_ack, ekey_hash_table1_rdata,
    output ekey_value_rd, ekey_value_raddr,
    input  ekey_value_ack, ekey_value_rdata,
    output resp_valid, resp_hit, resp_value, resp_tag,
    input  resp_ready,
    output hit_cnt, miss_cnt
  );
endinterface

// File: rtl/encap_ekey_lookup.sv
// Encap ekey lookup engine: reads two hash-table buckets in parallel,
// matches four candidate entries against the key, fetches the value on a
// hit and returns value/hit/tag. Single lookup in flight.
module encap_ekey_lookup #(
  parameter int DEPTH_NBITS       = 10,
  parameter int KEY_NBITS         = 24,
  parameter int VALUE_DEPTH_NBITS = 10,
  parameter int VALUE_NBITS       = 288,
  parameter int TAG_NBITS         = 8,
  parameter int BUCKET_NBITS      = 2*(1+KEY_NBITS+VALUE_DEPTH_NBITS)
) (
  input logic               clk,
  input logic               rst,
  encap_ekey_lookup_if.slave bus
);
  localparam int ENTRY_NBITS = 1 + KEY_NBITS + VALUE_DEPTH_NBITS;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HT_WAIT  = 3'd1;
  localparam logic [2:0] S_CMP      = 3'd2;
  localparam logic [2:0] S_VAL_WAIT = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]                   state;
  logic [KEY_NBITS-1:0]         key_q;
  logic [TAG_NBITS-1:0]         tag_q;
  logic [BUCKET_NBITS-1:0]      bucket0_q;
  logic [BUCKET_NBITS-1:0]      bucket1_q;
  logic                         done0;
  logic                         done1;
  logic                         req_ready_q;
  logic                         ht0_rd;
  logic                         ht1_rd;
  logic [DEPTH_NBITS-1:0]       ht0_addr;
  logic [DEPTH_NBITS-1:0]       ht1_addr;
  logic                         val_rd;
  logic [VALUE_DEPTH_NBITS-1:0] val_addr;
  logic                         resp_valid_q;
  logic                         resp_hit_q;
  logic [VALUE_NBITS-1:0]       resp_value_q;
  logic [TAG_NBITS-1:0]         resp_tag_q;
  logic [31:0]                  hit_cnt_q;
  logic [31:0]                  miss_cnt_q;

  // Candidate order is priority order: b0e0, b0e1, b1e0, b1e1
  logic [3:0][ENTRY_NBITS-1:0]  cand;
  logic [3:0]                   match;
  logic                         any_hit;
  logic [VALUE_DEPTH_NBITS-1:0] win_ptr;

  logic                         accept;
  logic                         both_done;
  logic                         resp_fire;

  assign cand      = {bucket1_q, bucket0_q};
  assign accept    = (state == S_IDLE) && req_ready_q && bus.req_valid;
  assign both_done = (done0 || bus.ekey_hash_table0_ack) &&
                     (done1 || bus.ekey_hash_table1_ack);
  assign resp_fire = (state == S_RESP) && resp_valid_q && bus.resp_ready;

  // Per-entry match: valid bit set and stored key equals the latched key
  always_comb begin
    for (int i = 0; i < 4; i++)
      match[i] = cand[i][ENTRY_NBITS-1] &&
                 (cand[i][ENTRY_NBITS-2 -: KEY_NBITS] == key_q);
  end

  // Priority select: lowest-index match wins (scan high to low, last write wins)
  always_comb begin
    win_ptr = '0;
    for (int i = 3; i >= 0; i--)
      if (match[i]) win_ptr = cand[i][VALUE_DEPTH_NBITS-1:0];
  end

  assign any_hit = |match;

  // Lookup FSM plus request latching, memory read pulses and response regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      key_q        <= '0;
      tag_q        <= '0;
      bucket0_q    <= '0;
      bucket1_q    <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      req_ready_q  <= 1'b0;
      ht0_rd       <= 1'b0;
      ht1_rd       <= 1'b0;
      ht0_addr     <= '0;
      ht1_addr     <= '0;
      val_rd       <= 1'b0;
      val_addr     <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_value_q <= '0;
      resp_tag_q   <= '0;
    end else begin
      ht0_rd <= 1'b0;
      ht1_rd <= 1'b0;
      val_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            key_q       <= bus.req_key;
            tag_q       <= bus.req_tag;
            ht0_rd      <= 1'b1;
            ht1_rd      <= 1'b1;
            ht0_addr    <= bus.req_hash0;
            ht1_addr    <= bus.req_hash1;
            done0       <= 1'b0;
            done1       <= 1'b0;
            req_ready_q <= 1'b0;
            state       <= S_HT_WAIT;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_HT_WAIT: begin
          if (bus.ekey_hash_table0_ack) begin
            bucket0_q <= bus.ekey_hash_table0_rdata;
            done0     <= 1'b1;
          end
          if (bus.ekey_hash_table1_ack) begin
            bucket1_q <= bus.ekey_hash_table1_rdata;
            done1     <= 1'b1;
          end
          if (both_done) state <= S_CMP;
        end
        S_CMP: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (any_hit) begin
            val_rd   <= 1'b1;
            val_addr <= win_ptr;
            state    <= S_VAL_WAIT;
          end else begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            resp_value_q <= '0;
            resp_tag_q   <= tag_q;
            state        <= S_RESP;
          end
        end
        S_VAL_WAIT: begin
          if (bus.ekey_value_ack) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_value_q <= bus.ekey_value_rdata;
            resp_tag_q   <= tag_q;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_fire) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Saturating hit/miss counters, stepped once per accepted response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (resp_fire) begin
      if (resp_hit_q) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign bus.req_ready              = req_ready_q;
  assign bus.ekey_hash_table0_rd    = ht0_rd;
  assign bus.ekey_hash_table0_raddr = ht0_addr;
  assign bus.ekey_hash_table1_rd    = ht1_rd;
  assign bus.ekey_hash_table1_raddr = ht1_addr;
  assign bus.ekey_value_rd          = val_rd;
  assign bus.ekey_value_raddr       = val_addr;
  assign bus.resp_valid             = resp_valid_q;
  assign bus.resp_hit               = resp_hit_q;
  assign bus.resp_value             = resp_value_q;
  assign bus.resp_tag               = resp_tag_q;
  assign bus.hit_cnt                = hit_cnt_q;
  assign bus.miss_cnt               = miss_cnt_q;
endmodule

// File: tb/tb_encap_ekey_lookup.sv
// Directed bench for encap_ekey_lookup with behavioural hash/value memories.
module tb_encap_ekey_lookup;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encap_ekey_lookup_if bus ();

  encap_ekey_lookup dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nchk = 0;
  int nfail = 0;

  logic [69:0] bank0 [0:1023];
  logic [69:0] bank1 [0:1023];
  int d0 = 1, d1 = 1, dv = 1;
  int vrd_cnt = 0;
  logic [9:0] vrd_addr = '0;
  int resp_seen = 0;

  function automatic logic [34:0] mk(input logic v, input logic [23:0] k, input logic [9:0] p);
    return {v, k, p};
  endfunction

  function automatic logic [287:0] vof(input logic [9:0] a);
    return {9{{22'h2A5A5, a}}};
  endfunction

  // Bank0 memory: ack d0 cycles after the read pulse
  always begin
    logic [9:0] a;
    @(posedge clk); #1;
    if (bus.ekey_hash_table0_rd) begin
      a = bus.ekey_hash_table0_raddr;
      repeat (d0) @(posedge clk);
      #1; bus.ekey_hash_table0_rdata = bank0[a]; bus.ekey_hash_table0_ack = 1'b1;
      @(posedge clk); #1; bus.ekey_hash_table0_ack = 1'b0;
    end
  end

  // Bank1 memory
  always begin
    logic [9:0] a;
    @(posedge clk); #1;
    if (bus.ekey_hash_table1_rd) begin
      a = bus.ekey_hash_table1_raddr;
      repeat (d1) @(posedge clk);
      #1; bus.ekey_hash_table1_rdata = bank1[a]; bus.ekey_hash_table1_ack = 1'b1;
      @(posedge clk); #1; bus.ekey_hash_table1_ack = 1'b0;
    end
  end

  // Value memory, also records read pulses
  always begin
    logic [9:0] a;
    @(posedge clk); #1;
    if (bus.ekey_value_rd) begin
      a = bus.ekey_value_raddr;
      vrd_cnt++;
      vrd_addr = a;
      repeat (dv) @(posedge clk);
      #1; bus.ekey_value_rdata = vof(a); bus.ekey_value_ack = 1'b1;
      @(posedge clk); #1; bus.ekey_value_ack = 1'b0;
    end
  end

  always @(negedge clk) if (bus.resp_valid === 1'b1) resp_seen++;

  task automatic send(input logic [23:0] k, input logic [9:0] h0, input logic [9:0] h1,
                      input logic [7:0] t);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    nchk++;
    if (bus.req_ready !== 1'b1) begin
      nfail++; $display("FAIL send_ready: req_ready=%b required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_key = k; bus.req_hash0 = h0; bus.req_hash1 = h1; bus.req_tag = t;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic accept_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    nchk++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.ekey_hash_table0_rd !== 1'b0 ||
        bus.ekey_value_rd !== 1'b0 || bus.hit_cnt !== 32'd0 || bus.miss_cnt !== 32'd0) begin
      nfail++; $display("FAIL reset_outputs: rdy=%b rv=%b hc=%0d mc=%0d required all 0",
                        bus.req_ready, bus.resp_valid, bus.hit_cnt, bus.miss_cnt);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if (bus.req_ready !== 1'b1) begin
      nfail++; $display("FAIL reset_ready: req_ready=%b required 1", bus.req_ready);
    end
  endtask

  task automatic test_hit();
    int cyc;
    int v0 = vrd_cnt;
    bank0[10'h010] = {mk(1'b1, 24'h123456, 10'h02A), mk(1'b1, 24'h111111, 10'h001)};
    bank1[10'h020] = {mk(1'b1, 24'h222222, 10'h003), mk(1'b1, 24'h333333, 10'h004)};
    send(24'h123456, 10'h010, 10'h020, 8'h5C);
    wait_resp(cyc);
    nchk++;
    if (cyc != 5) begin nfail++; $display("FAIL hit_latency: %0d cycles required 5", cyc); end
    nchk++;
    if (vrd_cnt != v0 + 1 || vrd_addr !== 10'h02A) begin
      nfail++; $display("FAIL hit_vrd: count=%0d addr=%h required 1 read at 02a", vrd_cnt - v0, vrd_addr);
    end
    nchk++;
    if (bus.resp_hit !== 1'b1 || bus.resp_value !== vof(10'h02A) || bus.resp_tag !== 8'h5C) begin
      nfail++; $display("FAIL hit_resp: hit=%b tag=%h value_ok=%b required hit=1 tag=5c",
                        bus.resp_hit, bus.resp_tag, bus.resp_value === vof(10'h02A));
    end
    accept_resp();
    nchk++;
    if (bus.hit_cnt !== 32'd1 || bus.miss_cnt !== 32'd0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      nfail++; $display("FAIL hit_after: hc=%0d mc=%0d rv=%b rdy=%b required 1 0 0 1",
                        bus.hit_cnt, bus.miss_cnt, bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_miss();
    int cyc;
    int v0 = vrd_cnt;
    bank0[10'h011] = {mk(1'b1, 24'hABCDEE, 10'h007), mk(1'b1, 24'h000000, 10'h008)};
    bank1[10'h021] = {mk(1'b1, 24'hABCDE0, 10'h00A), mk(1'b0, 24'hABCDEF, 10'h00B)};
    send(24'hABCDEF, 10'h011, 10'h021, 8'h33);
    wait_resp(cyc);
    nchk++;
    if (cyc != 3) begin nfail++; $display("FAIL miss_latency: %0d cycles required 3", cyc); end
    nchk++;
    if (vrd_cnt != v0) begin nfail++; $display("FAIL miss_vrd: %0d value reads required 0", vrd_cnt - v0); end
    nchk++;
    if (bus.resp_hit !== 1'b0 || bus.resp_value !== 288'd0 || bus.resp_tag !== 8'h33) begin
      nfail++; $display("FAIL miss_resp: hit=%b tag=%h value_zero=%b required 0 33 1",
                        bus.resp_hit, bus.resp_tag, bus.resp_value === 288'd0);
    end
    accept_resp();
    nchk++;
    if (bus.miss_cnt !== 32'd1 || bus.hit_cnt !== 32'd1) begin
      nfail++; $display("FAIL miss_cnt: mc=%0d hc=%0d required 1 1", bus.miss_cnt, bus.hit_cnt);
    end
  endtask

  task automatic test_skew_priority();
    int cyc;
    d0 = 4; d1 = 1;
    bank0[10'h030] = {mk(1'b1, 24'h777777, 10'h011), mk(1'b1, 24'h0F0F0F, 10'h005)};
    bank1[10'h040] = {mk(1'b0, 24'h0F0F0F, 10'h00C), mk(1'b1, 24'h0F0F0F, 10'h009)};
    send(24'h0F0F0F, 10'h030, 10'h040, 8'hA1);
    wait_resp(cyc);
    nchk++;
    if (vrd_addr !== 10'h005 || bus.resp_hit !== 1'b1 || bus.resp_value !== vof(10'h005)) begin
      nfail++; $display("FAIL skew_priority: addr=%h hit=%b required addr 005 hit 1", vrd_addr, bus.resp_hit);
    end
    nchk++;
    if (cyc != 8) begin nfail++; $display("FAIL skew_latency: %0d cycles required 8", cyc); end
    accept_resp();
    d0 = 1;
    // Only bank1 entry1 matches (entry0 holds same key but invalid); max pointer
    bank0[10'h050] = {mk(1'b1, 24'h0F0F0E, 10'h001), mk(1'b0, 24'h00AA55, 10'h002)};
    bank1[10'h3FF] = {mk(1'b1, 24'h00AA55, 10'h3FF), mk(1'b0, 24'h00AA55, 10'h100)};
    send(24'h00AA55, 10'h050, 10'h3FF, 8'hFF);
    wait_resp(cyc);
    nchk++;
    if (vrd_addr !== 10'h3FF || bus.resp_hit !== 1'b1 || bus.resp_tag !== 8'hFF) begin
      nfail++; $display("FAIL b1e1_hit: addr=%h hit=%b tag=%h required 3ff 1 ff", vrd_addr, bus.resp_hit, bus.resp_tag);
    end
    accept_resp();
    nchk++;
    if (bus.hit_cnt !== 32'd3) begin nfail++; $display("FAIL skew_cnt: hc=%0d required 3", bus.hit_cnt); end
  endtask

  task automatic test_invalid_match();
    int cyc;
    bank0[10'h060] = {mk(1'b0, 24'h5A5A5A, 10'h001), mk(1'b0, 24'h5A5A5A, 10'h002)};
    bank1[10'h061] = {mk(1'b0, 24'h5A5A5A, 10'h003), mk(1'b0, 24'h5A5A5A, 10'h004)};
    send(24'h5A5A5A, 10'h060, 10'h061, 8'h11);
    wait_resp(cyc);
    nchk++;
    if (cyc != 3 || bus.resp_hit !== 1'b0 || bus.resp_value !== 288'd0) begin
      nfail++; $display("FAIL invalid_match: cyc=%0d hit=%b required 3 0", cyc, bus.resp_hit);
    end
    accept_resp();
    nchk++;
    if (bus.miss_cnt !== 32'd2) begin nfail++; $display("FAIL invalid_cnt: mc=%0d required 2", bus.miss_cnt); end
  endtask

  task automatic test_backpressure();
    int cyc;
    bank0[10'h070] = {mk(1'b0, 24'h000000, 10'h000), mk(1'b1, 24'hC0FFEE, 10'h0EE)};
    send(24'hC0FFEE, 10'h070, 10'h071, 8'h77);
    wait_resp(cyc);
    bus.req_valid = 1'b1; bus.req_key = 24'h123456; bus.req_hash0 = 10'h010; bus.req_tag = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      nchk++;
      if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b1 || bus.resp_value !== vof(10'h0EE) ||
          bus.resp_tag !== 8'h77 || bus.req_ready !== 1'b0) begin
        nfail++; $display("FAIL bp_hold[%0d]: rv=%b hit=%b tag=%h rdy=%b required 1 1 77 0",
                          i, bus.resp_valid, bus.resp_hit, bus.resp_tag, bus.req_ready);
      end
    end
    bus.req_valid = 1'b0;
    accept_resp();
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (bus.hit_cnt !== 32'd4 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      nfail++; $display("FAIL bp_once: hc=%0d rv=%b rdy=%b required 4 0 1", bus.hit_cnt, bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int v0 = vrd_cnt;
    int r0;
    dv = 8;
    send(24'h123456, 10'h010, 10'h020, 8'h42);
    while (vrd_cnt == v0 && n < 20) begin @(posedge clk); #1; n++; end
    nchk++;
    if (vrd_cnt == v0) begin nfail++; $display("FAIL mid_vrd: no value read within %0d cycles", n); end
    rst = 1'b1;
    #1;
    nchk++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.hit_cnt !== 32'd0 || bus.miss_cnt !== 32'd0) begin
      nfail++; $display("FAIL mid_reset: rdy=%b rv=%b hc=%0d mc=%0d required 0", bus.req_ready, bus.resp_valid,
                        bus.hit_cnt, bus.miss_cnt);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    r0 = resp_seen;
    repeat (12) @(posedge clk);
    #1;
    nchk++;
    if (resp_seen != r0 || bus.req_ready !== 1'b1 || bus.hit_cnt !== 32'd0 || bus.miss_cnt !== 32'd0) begin
      nfail++; $display("FAIL mid_stale: resp_cycles=%0d rdy=%b hc=%0d mc=%0d required 0 1 0 0",
                        resp_seen - r0, bus.req_ready, bus.hit_cnt, bus.miss_cnt);
    end
    dv = 1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin bank0[i] = '0; bank1[i] = '0; end
    bus.req_valid = 1'b0; bus.req_key = '0; bus.req_hash0 = '0; bus.req_hash1 = '0; bus.req_tag = '0;
    bus.resp_ready = 1'b0;
    bus.ekey_hash_table0_ack = 1'b0; bus.ekey_hash_table0_rdata = '0;
    bus.ekey_hash_table1_ack = 1'b0; bus.ekey_hash_table1_rdata = '0;
    bus.ekey_value_ack = 1'b0; bus.ekey_value_rdata = '0;
    test_reset();
    test_hit();
    test_miss();
    test_skew_priority();
    test_invalid_match();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/encap_ekey_lookup.md
Name: encap_ekey_lookup

Overview:
- Lookup engine directly upstream of the encap ekey memory block.
- Accepts a key plus two precomputed bucket hashes, reads both ekey hash-table banks in parallel, and compares the four candidate entries against the key.
- On a hit, reads the ekey value memory at the matching entry's pointer and returns value plus hit flag to the encap datapath.
- One lookup in flight at a time; memory latency is variable and ack-driven.

Parameters:
DEPTH_NBITS, 10, hash-table address width per bank
KEY_NBITS, 24, ekey width
VALUE_DEPTH_NBITS, 10, value-memory address width (entry pointer width)
VALUE_NBITS, 288, value width returned by value memory
TAG_NBITS, 8, opaque request tag carried to response
BUCKET_NBITS, 2*(1+KEY_NBITS+VALUE_DEPTH_NBITS), derived bucket width, two entries per bucket

Ports:
clk  in  1  core clock
`RESET_SIG  in  1  reset
req_valid  in  1  lookup request
req_ready  out  1  engine idle, accepts request
req_key  in  KEY_NBITS  key to match
req_hash0  in  DEPTH_NBITS  bank0 bucket address
req_hash1  in  DEPTH_NBITS  bank1 bucket address
req_tag  in  TAG_NBITS  request tag
ekey_hash_table0_rd  out  1  bank0 read pulse
ekey_hash_table0_raddr  out  DEPTH_NBITS  bank0 read address
ekey_hash_table0_ack  in  1  bank0 read data valid
ekey_hash_table0_rdata  in  BUCKET_NBITS  bank0 bucket
ekey_hash_table1_rd  out  1  bank1 read pulse
ekey_hash_table1_raddr  out  DEPTH_NBITS  bank1 read address
ekey_hash_table1_ack  in  1  bank1 read data valid
ekey_hash_table1_rdata  in  BUCKET_NBITS  bank1 bucket
ekey_value_rd  out  1  value read pulse
ekey_value_raddr  out  VALUE_DEPTH_NBITS  value read address
ekey_value_ack  in  1  value data valid
ekey_value_rdata  in  VALUE_NBITS  value data
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_hit  out  1  key matched
resp_value  out  VALUE_NBITS  value on hit, 0 on miss
resp_tag  out  TAG_NBITS  echoed tag
hit_cnt  out  32  saturating hit counter
miss_cnt  out  32  saturating miss counter

Behaviour:
- Clock and reset: one clock (clk); reset (`RESET_SIG) is asynchronous and active-high. All outputs and state are 0 in reset; FSM starts in IDLE; req_ready=1 after the first clock following deassertion.
- Entry format: entry = {valid, key, ptr}, valid at MSB. Entry0 occupies bucket[BUCKET_NBITS/2-1:0]; entry1 occupies the upper half.
- FSM states: IDLE, HT_WAIT, CMP, VAL_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch key, tag and hashes.
  - Same edge: registered ekey_hash_table0_rd and ekey_hash_table1_rd pulse high for exactly 1 cycle, with raddr = hash0/hash1.
  - Go to HT_WAIT.
- HT_WAIT:
  - Acks may arrive in any order or in the same cycle; latch each rdata on its ack and set a per-bank done flag.
  - When both flags are set (including the cycle the second ack arrives), go to CMP.
  - Acks arriving outside HT_WAIT are ignored.
- CMP (1 cycle):
  - Match = valid & key==latched key.
  - Priority: bank0 entry0 > bank0 entry1 > bank1 entry0 > bank1 entry1.
  - Hit: pulse ekey_value_rd for 1 cycle with raddr = winning ptr; go to VAL_WAIT.
  - Miss: resp_hit=0, resp_value=0; go to RESP.
- VAL_WAIT: on ekey_value_ack, latch rdata into resp_value, set resp_hit=1, go to RESP.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready.
  - On the resp_valid&resp_ready cycle: increment hit_cnt or miss_cnt (saturate at 32'hFFFFFFFF), then return to IDLE.
  - req_ready rises the following cycle; no back-to-back bypass.
- req_ready=0 in every state other than IDLE; req_valid while not ready is ignored and not latched.
- Duplicate valid keys: the highest-priority match wins; no error is flagged.
- Reset mid-lookup: FSM returns to IDLE and all flags and outputs clear; stale acks after reset are dropped.
- Latency: with 1-cycle memory acks, hit = request edge to resp_valid in 5 cycles; miss = 3 cycles.

Test Plan:
- Hit, bank0 entry1: key 0x123456 at bank0[0x010] entry1, ptr 0x2A; both acks at +1 -> value rd addr 0x2A, resp_hit=1, resp_value=mem[0x2A], resp_tag echoed, hit_cnt=1.
- Miss: neither bank holds key 0xABCDEF -> no ekey_value_rd pulse, resp_hit=0, resp_value=0, miss_cnt=1.
- Skewed acks and priority: bank1 ack 3 cycles before bank0; key valid in bank0 entry0 (ptr 5) and bank1 entry0 (ptr 9) -> raddr=5.
- Invalid match: key present with valid=0 in all four entries -> miss.
- Backpressure: resp_ready low 4 cycles -> resp_* stable, req_ready=0, counter increments once only.
- Reset asserted in VAL_WAIT, late value ack after release -> no resp_valid, req_ready=1, counters 0.
